// File: rtl/day4_alu.sv
// Single-cycle execute-stage ALU: eight unsigned ops sampled on valid_i, with the result
// and zero/carry flags registered one clock later.
module day4_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] alu_o,
  output logic             valid_o,
  output logic             zero_o,
  output logic             carry_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_LSR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_EQL = 3'b111;

  logic [WIDTH:0]   sum_full;
  logic [WIDTH:0]   diff_full;
  logic             shift_oob;
  logic [WIDTH-1:0] sll_stage [SHW+1];
  logic [WIDTH-1:0] lsr_stage [SHW+1];

  logic [WIDTH-1:0] res;
  logic             res_carry;

  logic [WIDTH-1:0] alu_d,   alu_q;
  logic             valid_d, valid_q;
  logic             zero_d,  zero_q;
  logic             carry_d, carry_q;

  assign sum_full  = {1'b0, a_i} + {1'b0, b_i};
  // The 9th bit of the wrapped difference is set exactly when a < b (borrow).
  assign diff_full = {1'b0, a_i} - {1'b0, b_i};

  // Any amount bit at or above log2(WIDTH) shifts every bit out.
  assign shift_oob = |b_i[WIDTH-1:SHW];

  assign sll_stage[0] = a_i;
  assign lsr_stage[0] = a_i;

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_barrel
      assign sll_stage[gi+1] = b_i[gi] ? (sll_stage[gi] << (1 << gi)) : sll_stage[gi];
      assign lsr_stage[gi+1] = b_i[gi] ? (lsr_stage[gi] >> (1 << gi)) : lsr_stage[gi];
    end
  endgenerate

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    case (op_i)
      OP_ADD: begin
        res       = sum_full[WIDTH-1:0];
        res_carry = sum_full[WIDTH];
      end
      OP_SUB: begin
        res       = diff_full[WIDTH-1:0];
        res_carry = diff_full[WIDTH];
      end
      OP_SLL: res = shift_oob ? '0 : sll_stage[SHW];
      OP_LSR: res = shift_oob ? '0 : lsr_stage[SHW];
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_EQL: res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      default: begin
        res       = '0;
        res_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    alu_d   = alu_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    valid_d = valid_i;
    if (valid_i) begin
      alu_d   = res;
      zero_d  = (res == '0);
      carry_d = res_carry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      alu_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign alu_o   = alu_q;
  assign valid_o = valid_q;
  assign zero_o  = zero_q;
  assign carry_o = carry_q;

endmodule

// File: tb/tb_day4_alu.sv
// Bench for day4_alu: directed vectors with literal expectations, plus an arithmetic
// reference model compared against the DUT on every falling clock edge.
module tb_day4_alu;

  logic       clk_i;
  logic       rst_n_i;
  logic       valid_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [2:0] op_i;
  logic [7:0] alu_o;
  logic       valid_o;
  logic       zero_o;
  logic       carry_o;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  logic [7:0] m_alu;
  logic       m_valid;
  logic       m_zero;
  logic       m_carry;

  day4_alu #(.WIDTH(8)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .op_i    (op_i),
    .alu_o   (alu_o),
    .valid_o (valid_o),
    .zero_o  (zero_o),
    .carry_o (carry_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {carry, result} computed with plain integer arithmetic.
  function automatic logic [8:0] model_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    int ia, ib, r, c;
    ia = int'(a);
    ib = int'(b);
    r = 0;
    c = 0;
    case (op)
      3'd0: begin r = (ia + ib) % 256; c = (ia + ib > 255) ? 1 : 0; end
      3'd1: begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
      3'd2: r = (ib >= 8) ? 0 : (ia * (2 ** ib)) % 256;
      3'd3: r = (ib >= 8) ? 0 : ia / (2 ** ib);
      3'd4: r = int'(a & b);
      3'd5: r = int'(a | b);
      3'd6: r = int'(a ^ b);
      default: r = (ia == ib) ? 1 : 0;
    endcase
    return {c[0], r[7:0]};
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_alu   <= 8'h00;
      m_valid <= 1'b0;
      m_zero  <= 1'b1;
      m_carry <= 1'b0;
    end else begin
      m_valid <= valid_i;
      if (valid_i) begin
        m_alu   <= model_alu(op_i, a_i, b_i) & 9'h0FF;
        m_carry <= model_alu(op_i, a_i, b_i) >> 8;
        m_zero  <= (model_alu(op_i, a_i, b_i) & 9'h0FF) == 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("model_alu",   int'(alu_o),   int'(m_alu));
      check("model_valid", int'(valid_o), int'(m_valid));
      check("model_zero",  int'(zero_o),  int'(m_zero));
      check("model_carry", int'(carry_o), int'(m_carry));
    end
  end

  task automatic run_vec(input string name, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic ez,
                         input logic ec);
    @(negedge clk_i);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    $display("vec %s op=%0d a=%02h b=%02h -> alu=%02h z=%0b c=%0b v=%0b",
             name, op, a, b, alu_o, zero_o, carry_o, valid_o);
    check({name, "_alu"},   int'(alu_o),   int'(er));
    check({name, "_zero"},  int'(zero_o),  int'(ez));
    check({name, "_carry"}, int'(carry_o), int'(ec));
    check({name, "_valid"}, int'(valid_o), 1);
  endtask

  initial begin
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    a_i     = 8'h00;
    b_i     = 8'h00;
    op_i    = 3'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_alu",   int'(alu_o),   0);
    check("reset_valid", int'(valid_o), 0);
    check("reset_zero",  int'(zero_o),  1);
    check("reset_carry", int'(carry_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cmp_en  = 1'b1;

    run_vec("add_10_05",  3'd0, 8'h10, 8'h05, 8'h15, 1'b0, 1'b0);
    run_vec("add_ff_01",  3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    run_vec("sub_15_03",  3'd1, 8'h15, 8'h03, 8'h12, 1'b0, 1'b0);
    run_vec("sub_03_05",  3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1);
    run_vec("sll_0f_2",   3'd2, 8'h0F, 8'h02, 8'h3C, 1'b0, 1'b0);
    run_vec("lsr_f0_3",   3'd3, 8'hF0, 8'h03, 8'h1E, 1'b0, 1'b0);
    run_vec("sll_ff_8",   3'd2, 8'hFF, 8'h08, 8'h00, 1'b1, 1'b0);
    run_vec("lsr_80_7",   3'd3, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0);
    run_vec("lsr_ff_20",  3'd3, 8'hFF, 8'h20, 8'h00, 1'b1, 1'b0);
    run_vec("and_cc_aa",  3'd4, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0);
    run_vec("or_cc_aa",   3'd5, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0);
    run_vec("xor_cc_aa",  3'd6, 8'hCC, 8'hAA, 8'h66, 1'b0, 1'b0);
    run_vec("eql_aa_aa",  3'd7, 8'hAA, 8'hAA, 8'h01, 1'b0, 1'b0);
    run_vec("eql_aa_cc",  3'd7, 8'hAA, 8'hCC, 8'h00, 1'b1, 1'b0);

    // Idle cycle with garbage operands: outputs must hold the EQL-false result.
    @(negedge clk_i);
    valid_i = 1'b0;
    op_i    = 3'd0;
    a_i     = 8'hFF;
    b_i     = 8'h01;
    @(posedge clk_i);
    #1;
    $display("idle -> alu=%02h z=%0b c=%0b v=%0b", alu_o, zero_o, carry_o, valid_o);
    check("hold_alu",   int'(alu_o),   0);
    check("hold_zero",  int'(zero_o),  1);
    check("hold_carry", int'(carry_o), 0);
    check("hold_valid", int'(valid_o), 0);

    // Carry set, then a non-arithmetic op must clear it.
    run_vec("sub_00_01",  3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
    run_vec("xor_ff_ff",  3'd6, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      op_i    = 3'($urandom_range(0, 7));
      a_i     = 8'($urandom);
      b_i     = (op_i == 3'd2 || op_i == 3'd3) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      valid_i = ($urandom_range(0, 3) != 0);
      @(posedge clk_i);
      #1;
      $display("rnd %0d op=%0d a=%02h b=%02h v_in=%0b -> alu=%02h z=%0b c=%0b v=%0b",
               i, op_i, a_i, b_i, valid_i, alu_o, zero_o, carry_o, valid_o);
    end

    // Mid-stream asynchronous reset while valid_i is held high.
    run_vec("pre_rst_add", 3'd0, 8'hFF, 8'h02, 8'h01, 1'b0, 1'b1);
    #2;
    rst_n_i = 1'b0;
    #1;
    $display("async reset -> alu=%02h z=%0b c=%0b v=%0b", alu_o, zero_o, carry_o, valid_o);
    check("mid_rst_alu",   int'(alu_o),   0);
    check("mid_rst_valid", int'(valid_o), 0);
    check("mid_rst_zero",  int'(zero_o),  1);
    check("mid_rst_carry", int'(carry_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    valid_i = 1'b0;
    run_vec("post_rst_add", 3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
